// File: rtl/fpu_pkg.sv
// Shared FP32 constants, delay-line entry type and special-case classifier
// for the FPU issue front ends.
package fpu_pkg;

  localparam int FP_W     = 32;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  localparam logic [FP_W-1:0]     FP_QNAN     = 32'h7FC00000;
  localparam logic [FP_W-1:0]     FP_PINF     = 32'h7F800000;
  localparam logic [FP_EXP_W-1:0] FP_EXP_ONES = 8'hFF;
  localparam logic [FP_EXP_W-1:0] FP_EXP_ZERO = 8'h00;
  localparam logic [FP_MAN_W-1:0] FP_MAN_ZERO = 23'd0;

  // Tag travels beside the entry because its width belongs to the issuing block.
  typedef struct packed {
    logic            v;
    logic            byp;
    logic [FP_W-1:0] bval;
    logic            inv;
  } dl_entry_t;

  // First matching rule wins; v is left clear for the caller to set.
  function automatic dl_entry_t classify(input logic [FP_W-1:0] x);
    dl_entry_t             c;
    logic                  s;
    logic [FP_EXP_W-1:0]   e;
    logic [FP_MAN_W-1:0]   m;
    s      = x[31];
    e      = x[30:23];
    m      = x[22:0];
    c.v    = 1'b0;
    c.byp  = 1'b1;
    c.inv  = 1'b0;
    c.bval = {FP_W{1'b0}};
    if (e == FP_EXP_ZERO) begin
      c.bval = {s, 31'b0};
    end else if ((e == FP_EXP_ONES) && (m != FP_MAN_ZERO)) begin
      c.bval = FP_QNAN;
      c.inv  = 1'b1;
    end else if (s) begin
      c.bval = FP_QNAN;
      c.inv  = 1'b1;
    end else if (e == FP_EXP_ONES) begin
      c.bval = FP_PINF;
    end else begin
      c.byp = 1'b0;
    end
    return c;
  endfunction

endpackage

// File: rtl/fpu_fifo.sv
// Parameterised first-word-fall-through FIFO with async active-high reset.
// Head entry is visible on rd_data whenever empty is low.
module fpu_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  // Explicit wrap so non-power-of-two depths index correctly.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign empty   = (count == {CNT_W{1'b0}});
  assign full    = (count == FULL_CNT);
  assign do_rd   = rd && !empty;
  assign do_wr   = wr && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else begin
      if (do_wr) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_rd) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {WIDTH{1'b0}};
      end
    end else if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  fpu_fifo_chk u_chk (
    .clk   (clk),
    .rst   (rst),
    .wr    (wr),
    .rd    (rd),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: rtl/fpu_fifo_chk.sv
// Protocol checker for fpu_fifo: no write into a full FIFO without a
// simultaneous pop, no pop from an empty FIFO.
module fpu_fifo_chk (
  input logic clk,
  input logic rst,
  input logic wr,
  input logic rd,
  input logic full,
  input logic empty
);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(wr && full && !rd))
    else $error("fpu_fifo overflow");

  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(rd && empty))
    else $error("fpu_fifo underflow");

endmodule

// File: rtl/fsqrt_issue.sv
// Issue/retire front end for the fixed two-cycle fsqrt datapath: classifies
// special operands, tracks in-flight work in a delay line, returns results in order.
module fsqrt_issue
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      sq_x,
  input  logic [31:0]      sq_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_inv
);

  localparam int CRED_W = $clog2(DEPTH + 1);
  localparam int ENT_W  = FP_W + TAG_W + 1;
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(DEPTH);

  dl_entry_t          cls;
  dl_entry_t          d1;
  dl_entry_t          d2;
  logic [TAG_W-1:0]   d1_tag;
  logic [TAG_W-1:0]   d2_tag;
  logic [CRED_W-1:0]  cred;
  logic               accept;
  logic               pop;
  logic               empty;
  logic [FP_W-1:0]    ret_y;
  logic [ENT_W-1:0]   wr_data;
  logic [ENT_W-1:0]   rd_data;

  assign sq_x      = in_x;
  assign in_ready  = (cred != {CRED_W{1'b0}});
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_valid = !empty;

  always_comb begin
    cls   = classify(in_x);
    cls.v = accept;
  end

  // D1 loads every edge so bubbles ride through as v=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1     <= '0;
      d2     <= '0;
      d1_tag <= {TAG_W{1'b0}};
      d2_tag <= {TAG_W{1'b0}};
    end else begin
      d1     <= cls;
      d1_tag <= in_tag;
      d2     <= d1;
      d2_tag <= d1_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cred <= CRED_MAX;
    end else begin
      case ({accept, pop})
        2'b10:   cred <= cred - CRED_W'(1);
        2'b01:   cred <= cred + CRED_W'(1);
        default: cred <= cred;
      endcase
    end
  end

  // sq_y is only meaningful in the cycle the compute entry sits in D2.
  always_comb begin
    if (d2.byp) begin
      ret_y = d2.bval;
    end else begin
      ret_y = sq_y;
    end
  end

  assign wr_data = {ret_y, d2_tag, d2.inv};

  fpu_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr      (d2.v),
    .wr_data (wr_data),
    .rd      (pop),
    .rd_data (rd_data),
    .empty   (empty)
  );

  assign {out_y, out_tag, out_inv} = rd_data;

endmodule

// File: tb/tb_fsqrt_issue.sv
// Directed bench for fsqrt_issue with a behavioural two-cycle fsqrt model.
module tb_fsqrt_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic [4:0]  in_tag;
  logic [31:0] sq_x;
  logic [31:0] sq_y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic [4:0]  out_tag;
  logic        out_inv;

  int total = 0;
  int bad   = 0;

  logic [31:0] vx  [8];
  logic [4:0]  vt  [8];
  logic [31:0] ey  [8];
  logic        ei  [8];
  logic [31:0] sq_r1;

  always #5 clk = ~clk;

  fsqrt_issue #(.TAG_W(5), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_tag    (in_tag),
    .sq_x      (sq_x),
    .sq_y      (sq_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_tag   (out_tag),
    .out_inv   (out_inv)
  );

  // Non-listed operands yield a poison value so a wrongly captured sq_y shows up.
  function automatic logic [31:0] model_root(input logic [31:0] x);
    case (x)
      32'h40800000: return 32'h40000000;
      32'h41100000: return 32'h40400000;
      default:      return 32'hDEADBEEF;
    endcase
  endfunction

  always @(posedge clk) begin
    sq_r1 <= model_root(sq_x);
    sq_y  <= sq_r1;
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int i, input logic [31:0] x, input logic [4:0] t,
                      input logic [31:0] y, input logic inv);
    vx[i] = x; vt[i] = t; ey[i] = y; ei[i] = inv;
  endtask

  // Vector i issues in cycle i; its result must be at the head in cycle i+3.
  task automatic run_stream(input string name, input int n);
    out_ready = 1'b1;
    for (int c = 0; c < n + 3; c++) begin
      if (c < n) begin
        in_valid = 1'b1;
        in_x     = vx[c];
        in_tag   = vt[c];
        chk({name, "_ready"}, {63'd0, in_ready}, 64'd1);
      end else begin
        in_valid = 1'b0;
      end
      if (c < 3) begin
        chk({name, "_early"}, {63'd0, out_valid}, 64'd0);
      end else begin
        chk({name, "_out"}, {25'd0, out_valid, out_y, out_tag, out_inv},
            {25'd0, 1'b1, ey[c-3], vt[c-3], ei[c-3]});
      end
      cyc();
    end
    chk({name, "_drained"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    int tag_n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = 32'h0;
    in_tag    = 5'd0;
    out_ready = 1'b1;
    #1;
    chk("reset_state", {56'd0, in_ready, out_valid, out_inv, out_tag},
        {56'd0, 1'b1, 1'b0, 1'b0, 5'd0});
    chk("reset_y", {32'd0, out_y}, 64'd0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    load(0, 32'h40800000, 5'd3, 32'h40000000, 1'b0);
    load(1, 32'h41100000, 5'd4, 32'h40400000, 1'b0);
    run_stream("compute", 2);

    load(0, 32'h80000000, 5'd5, 32'h80000000, 1'b0);
    load(1, 32'hC0800000, 5'd6, 32'h7FC00000, 1'b1);
    load(2, 32'h7FC00001, 5'd7, 32'h7FC00000, 1'b1);
    load(3, 32'h7F800000, 5'd8, 32'h7F800000, 1'b0);
    load(4, 32'h00000001, 5'd9, 32'h00000000, 1'b0);
    run_stream("special", 5);

    load(0, 32'h40800000, 5'd1, 32'h40000000, 1'b0);
    load(1, 32'hBF800000, 5'd2, 32'h7FC00000, 1'b1);
    load(2, 32'h41100000, 5'd3, 32'h40400000, 1'b0);
    run_stream("mixed", 3);

    // Backpressure: four credits, then stall until one is returned.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_x      = 32'h40800000;
    tag_n     = 10;
    for (int c = 0; c < 8; c++) begin
      in_tag = 5'(tag_n);
      chk("bp_ready", {63'd0, in_ready}, {63'd0, (c < 4) ? 1'b1 : 1'b0});
      if (c < 4) tag_n++;
      cyc();
    end
    chk("bp_head", {25'd0, out_valid, out_y, out_tag, out_inv},
        {25'd0, 1'b1, 32'h40000000, 5'd10, 1'b0});
    in_tag    = 5'(tag_n);
    out_ready = 1'b1;
    chk("bp_pop_cycle_ready", {63'd0, in_ready}, 64'd0);
    cyc();
    out_ready = 1'b0;
    chk("bp_credit_back", {63'd0, in_ready}, 64'd1);
    cyc();
    in_valid = 1'b0;
    chk("bp_credit_used", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    for (int k = 11; k <= 14; k++) begin
      chk("bp_drain", {25'd0, out_valid, out_y, out_tag, out_inv},
          {25'd0, 1'b1, 32'h40000000, 5'(k), 1'b0});
      cyc();
    end
    chk("bp_empty", {63'd0, out_valid}, 64'd0);
    chk("bp_ready_final", {63'd0, in_ready}, 64'd1);

    // Reset with two results queued and two still in the delay line.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_x   = (c == 1) ? 32'hBF800000 : 32'h41100000;
      in_tag = 5'(20 + c);
      cyc();
    end
    in_valid = 1'b0;
    chk("pre_reset_queued", {58'd0, out_valid, out_tag}, {58'd0, 1'b1, 5'd20});
    chk("pre_reset_ready", {63'd0, in_ready}, 64'd0);
    rst = 1'b1;
    #1;
    chk("mid_reset", {24'd0, in_ready, out_valid, out_inv, out_tag, out_y},
        {24'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0});
    cyc();
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      chk("no_stale", {63'd0, out_valid}, 64'd0);
      cyc();
    end

    load(0, 32'h41100000, 5'd17, 32'h40400000, 1'b0);
    run_stream("after_reset", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsqrt_issue.md
# fsqrt_issue

Valid/ready issue-and-retire front end for the fixed-latency, handshake-free `fsqrt` datapath. It accepts tagged FP32 operands and resolves IEEE special cases locally. Normal operands go to `fsqrt`, whose result is captured exactly two cycles later. All results, bypassed and computed, are returned in order through a credit-protected output FIFO with backpressure. It sits between the FPU dispatch logic and register writeback. `fsqrt` is instantiated beside it at the FPU top level.

## Interface
- `TAG_W`, 5 — width of the opaque tag carried with each operation
- `DEPTH`, 4 — output FIFO entries; must be ≥ 4 for one-per-cycle throughput
- `clk`  in  1  — clock
- `rst`  in  1  — asynchronous, active-high reset
- `in_valid`  in  1  — operand offered
- `in_ready`  out  1  — operand accepted when `in_valid && in_ready`
- `in_x`  in  32  — FP32 operand
- `in_tag`  in  TAG_W  — tag of the operand
- `sq_x`  out  32  — operand to `fsqrt.x`
- `sq_y`  in  32  — result from `fsqrt.y`
- `out_valid`  out  1  — result available
- `out_ready`  in  1  — consumer takes result when `out_valid && out_ready`
- `out_y`  out  32  — FP32 result
- `out_tag`  out  TAG_W  — tag of the result
- `out_inv`  out  1  — invalid-operation flag

## Operation
- `sq_x = in_x` combinationally, at all times. `fsqrt` has no valid signal, so the delay line alone determines which `sq_y` values are captured.
- Classification happens at accept time. `e` is `in_x[30:23]`, `m` is `in_x[22:0]`, and the first matching rule applies:
  - `e==0` (zero or denormal): bypass with `{s,31'b0}`, inv=0.
  - `e==255` and `m!=0` (NaN): bypass with 32'h7FC00000, inv=1.
  - `s==1` (negative nonzero, including −inf): bypass with 32'h7FC00000, inv=1.
  - `e==255` (+inf): bypass with 32'h7F800000, inv=0.
  - Otherwise: compute, taking `sq_y`, inv=0.
- Delay line:
  - Two registered stages, D1 and D2. Each holds {v, tag, byp, bval, inv}.
  - D1 loads on every edge; `v` equals the accept. D2 loads from D1.
  - Bubbles propagate as v=0.
- Retire: when D2.v=1, write {byp ? bval : sq_y, tag, inv} into the FIFO at the end of that cycle.
- Credits:
  - Counter `cred` with range 0..DEPTH; reset value DEPTH.
  - Accept decrements it. FIFO pop (`out_valid && out_ready`) increments it. Both in one cycle leave it unchanged.
  - `in_ready = (cred != 0)`. It is registered-derived and must not depend on `in_valid` or `out_ready`.
- Credits guarantee the FIFO never overflows, so a retire write is never refused. Overflow is an assertion, not a handled case.
- The FIFO is first-word-fall-through. `out_valid` means not empty, and `out_y`/`out_tag`/`out_inv` show the head entry.
- Simultaneous write and pop on a non-empty FIFO: both happen and the count is unchanged. On an empty FIFO the write lands and `out_valid` rises next cycle; data never passes through combinationally.

## Timing
- An accept in cycle n means:
  - `fsqrt` samples `sq_x` at the end of n.
  - D1 is valid in n+1; D2 is valid in n+2, when `sq_y` holds this operand's root.
  - The FIFO write happens at the end of n+2.
  - `out_valid` rises in n+3 at the earliest. Latency is 3 cycles for both bypass and compute.
- Throughput is one accept per cycle while the consumer holds `out_ready=1`. The round trip from accept to credit return is 4 cycles, so DEPTH=4 is sufficient.
- Ordering: results leave strictly in accept order, bypass results included.
- Reset values:
  - `in_ready`=1, `out_valid`=0, `out_y`=0, `out_tag`=0, `out_inv`=0.
  - D1.v = D2.v = 0, FIFO empty, `cred`=DEPTH.
- Reset mid-operation discards all in-flight and queued results. `fsqrt` output after reset is ignored because D2.v=0.

## Structure
- `fpu_pkg` holds the shared constants and types:
  - FP32 constants `FP_QNAN`=32'h7FC00000 and `FP_PINF`=32'h7F800000.
  - Field widths and exponent all-ones/zero constants.
  - A packed struct for the delay-line entry.
- Sub-module `fpu_fifo`: a parameterised synchronous first-word-fall-through FIFO (WIDTH, DEPTH) with async active-high reset. It is reusable by other FPU issue blocks.
- The delay line, classifier and credit counter stay in `fsqrt_issue`.

## Test plan
- Hook up a behavioural 2-cycle `fsqrt` model and drive it back-to-back:
  - Issue 0x40800000 (4.0) with tag 3, then 0x41100000 (9.0) with tag 4.
  - Required: 0x40000000/tag 3 in cycle n+3, then 0x40400000/tag 4 in n+4, both with inv=0.
- Special cases, one per cycle:
  - 0x80000000 → 0x80000000.
  - 0xC0800000 → 0x7FC00000 with inv=1.
  - 0x7FC00001 → 0x7FC00000 with inv=1.
  - 0x7F800000 → 0x7F800000.
  - 0x00000001 → 0x00000000.
  - Required: all in order, each 3 cycles after its accept.
- Interleave bypass and compute (4.0, −1.0, 9.0):
  - Required: tags emerge in accept order, with `sq_y` captured only for the compute entries.
- Backpressure with `out_ready=0` and continuous `in_valid`:
  - Required: exactly 4 accepts, after which `in_ready`=0.
  - Raising `out_ready` for one cycle returns one credit, giving `in_ready`=1 the next cycle. No loss or duplication.
- Reset asserted with 2 operands in flight and 2 queued:
  - Required: `out_valid`=0 and `in_ready`=1 immediately.
  - No stale result ever appears afterwards.
